dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Memory-side responder for a pipeline MemRead/MemWrite request interface.
// Each access waits WAIT_CYCLES states, then completes with a one-cycle done pulse.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        mem_stall,
  output logic        mem_done,
  output logic        mem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [CW-1:0]   cnt_r;
  logic [AW-1:0]   idx_r;
  logic [31:0]     wdata_r;
  logic            wr_r;
  logic            err_r;
  logic            req_s;
  logic            wait_last_s;
  logic [31:0]     mem_r [DEPTH_WORDS];

  // Address bits above the word index alias onto the same words.
  logic            unused_addr_s;
  assign unused_addr_s = ^addr[31:AW+2];

  assign req_s       = MemRead | MemWrite;
  assign wait_last_s = (state_r == WAIT) && (cnt_r == '0);

  // Next-state decode and combinational pipeline hold request.
  always_comb begin
    state_s   = state_r;
    mem_stall = 1'b0;
    if (rst) begin
      state_s   = IDLE;
      mem_stall = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            state_s   = WAIT;
            mem_stall = 1'b1;
          end else begin
            state_s   = IDLE;
          end
        end
        WAIT: begin
          mem_stall = 1'b1;
          if (cnt_r == '0) begin
            state_s = RESP;
          end else begin
            state_s = WAIT;
          end
        end
        RESP:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register, wait counter and registered response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      mem_done  <= 1'b0;
      mem_err   <= 1'b0;
      read_data <= 32'h0000_0000;
    end else begin
      state_r  <= state_s;
      mem_done <= wait_last_s;
      mem_err  <= wait_last_s & err_r;
      case (state_r)
        IDLE: begin
          if (req_s) begin
            cnt_r <= CW'(WAIT_CYCLES - 1);
          end
        end
        WAIT: begin
          if (cnt_r != '0) begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        RESP: begin
          if (!wr_r) begin
            read_data <= mem_r[idx_r];
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

  // Request latch; a simultaneous read+write is carried out as a write.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == IDLE) && req_s) begin
      idx_r   <= addr[AW+1:2];
      wdata_r <= write_data;
      wr_r    <= MemWrite;
      err_r   <= (MemRead & MemWrite) | (addr[1:0] != 2'b00);
    end
  end

  // Store commit on the RESP edge only; contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && (state_r == RESP) && wr_r) begin
      mem_r[idx_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a transaction-level reference model.
module tb_dmem_responder;

  localparam int W = 2;
  localparam int D = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        mem_stall;
  logic        mem_done;
  logic        mem_err;

  dmem_responder #(.DEPTH_WORDS(D), .WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .write_data(write_data), .read_data(read_data),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  // Reference model: one access in flight, timed by its acceptance cycle.
  int          cyc = 0;
  int          t0 = 0;
  bit          busy = 1'b0;
  logic [31:0] l_addr = 32'h0;
  logic [31:0] l_data = 32'h0;
  bit          l_wr = 1'b0;
  bit          l_err = 1'b0;
  logic [31:0] exp_rd = 32'h0;
  logic [31:0] mem_m [D];

  always @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      exp_rd <= 32'h0;
    end else if (busy) begin
      if (cyc == t0 + W + 1) begin
        if (l_wr) mem_m[int'((l_addr / 32'd4) % D)] <= l_data;
        else      exp_rd <= mem_m[int'((l_addr / 32'd4) % D)];
        busy <= 1'b0;
      end
    end else if (MemRead || MemWrite) begin
      busy   <= 1'b1;
      t0     <= cyc;
      l_addr <= addr;
      l_data <= write_data;
      l_wr   <= MemWrite;
      l_err  <= (MemRead && MemWrite) || (addr % 32'd4 != 32'd0);
    end
    cyc <= cyc + 1;
  end

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                        input logic [31:0] d, output int lat, output bit err_seen);
    @(posedge clk); #1;
    MemRead = rd; MemWrite = wr; addr = a; write_data = d;
    lat = -1; err_seen = 1'b0;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_done) begin
        lat = i;
        err_seen = mem_err;
      end
    end
    @(posedge clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int lat;
  bit err;
  int d1;
  int d2;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("stall", {31'd0, mem_stall},
                {31'd0, !rst && (busy ? (cyc <= t0 + W) : (MemRead || MemWrite))});
          check("done", {31'd0, mem_done}, {31'd0, busy && (cyc == t0 + W + 1)});
          check("err", {31'd0, mem_err}, {31'd0, busy && (cyc == t0 + W + 1) && l_err});
          check("read_data", read_data, exp_rd);
        end
      end
    join_none

    @(negedge clk);
    check("rst_read_data", read_data, 32'h0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_done", {31'd0, mem_done}, 32'd0);

    access(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, err);
    check("wr_latency", lat, 32'd3);
    check("wr_err", {31'd0, err}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, err);
    check("rd_latency", lat, 32'd3);
    @(negedge clk);
    check("rd_word4", read_data, 32'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h44, 32'h0000_5555, lat, err);
    @(negedge clk);
    check("rd_held_after_wr", read_data, 32'hDEAD_BEEF);

    access(1'b0, 1'b1, 32'h400, 32'h1234_5678, lat, err);
    access(1'b1, 1'b0, 32'h0, 32'h0, lat, err);
    check("alias_rd", read_data, 32'h1234_5678);

    access(1'b1, 1'b1, 32'h20, 32'hA5A5_A5A5, lat, err);
    check("conflict_err", {31'd0, err}, 32'd1);
    access(1'b1, 1'b0, 32'h20, 32'h0, lat, err);
    check("conflict_word8", read_data, 32'hA5A5_A5A5);
    check("clean_rd_err", {31'd0, err}, 32'd0);

    access(1'b0, 1'b1, 32'h13, 32'h1, lat, err);
    check("misalign_err", {31'd0, err}, 32'd1);
    access(1'b1, 1'b0, 32'h10, 32'h0, lat, err);
    check("misalign_word4", read_data, 32'h1);

    // Reset in the first WAIT cycle must abort the pending store.
    access(1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, lat, err);
    @(posedge clk); #1;
    MemWrite = 1'b1; addr = 32'h30; write_data = 32'h0000_FFFF;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; MemWrite = 1'b0;
    @(negedge clk);
    check("abort_stall", {31'd0, mem_stall}, 32'd0);
    check("abort_read_data", read_data, 32'h0);
    repeat (5) @(negedge clk);
    access(1'b1, 1'b0, 32'h30, 32'h0, lat, err);
    check("abort_word12", read_data, 32'hCAFE_F00D);

    // Inputs changed mid-WAIT are ignored.
    @(posedge clk); #1;
    MemWrite = 1'b1; addr = 32'h40; write_data = 32'h1111_1111;
    @(posedge clk); #1;
    MemWrite = 1'b0; MemRead = 1'b1; addr = 32'h80; write_data = 32'h0;
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      @(negedge clk);
      if (mem_done) lat = i;
    end
    if (lat < 0) check("chg_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    MemRead = 1'b0;
    access(1'b1, 1'b0, 32'h40, 32'h0, lat, err);
    check("chg_word16", read_data, 32'h1111_1111);

    // Held request restarts after exactly one IDLE cycle.
    @(posedge clk); #1;
    MemRead = 1'b1; addr = 32'h10;
    d1 = -1; d2 = -1;
    for (int i = 0; i < 30 && d2 < 0; i++) begin
      @(negedge clk);
      if (mem_done) begin
        if (d1 < 0) d1 = i;
        else d2 = i;
      end
    end
    @(posedge clk); #1;
    MemRead = 1'b0;
    check("b2b_first", d1, 32'd3);
    check("b2b_gap", d2 - d1, 32'd4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
